// File: rtl/fifo_burst_reader.sv
`default_nettype none
// ============================================================================
// Module   : fifo_burst_reader
// Purpose  : Read-side consumer for an 8-bit synchronous FIFO. Waits until the
//            FIFO holds a full burst, or until an idle timeout expires with a
//            partial load. Then it issues read strobes and re-emits the bytes
//            on a valid/ready stream. The final byte of each burst is tagged
//            with m_last.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            fifo_empty/count    - FIFO status inputs
//            fifo_dout           - FIFO read data (1-cycle read latency)
//            fifo_read           - FIFO read strobe
//            m_data/valid/ready  - output stream
//            m_last              - last byte of burst (qualified by m_valid)
//            busy                - high in READ and DRAIN
// Option   : FIFO_BURST_READER_PARITY_EN adds m_parity (even parity of m_data)
//            and parity_byte (XOR of all bytes of the current burst).
// Revision : 1.0 - initial release
// ============================================================================
module fifo_burst_reader #(
    parameter int DATA_W    = 8,
    parameter int CNT_W     = 4,
    parameter int BURST_LEN = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    input  logic [CNT_W-1:0]  fifo_count,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              fifo_read,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
`ifdef FIFO_BURST_READER_PARITY_EN
    output logic              m_parity,
    output logic [DATA_W-1:0] parity_byte,
`endif
    output logic              busy
);

    localparam int                c_tmr_w     = $clog2(TIMEOUT + 1);
    localparam logic [c_tmr_w-1:0] c_tmr_max  = c_tmr_w'(TIMEOUT);
    localparam logic [CNT_W-1:0]   c_burst_len = CNT_W'(BURST_LEN);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [c_tmr_w-1:0]  timer_q, timer_d;
    logic [CNT_W-1:0]    rd_left_q, rd_left_d;
    logic                inflight_q, inflight_d;
    logic                inflight_last_q, inflight_last_d;

    // Two-entry skid buffer; entry 0 is the head presented on the stream.
    logic [1:0]          occ_q, occ_d;
    logic [DATA_W-1:0]   data0_q, data0_d, data1_q, data1_d;
    logic                last0_q, last0_d, last1_q, last1_d;

    logic                w_pop;
    logic                w_space;

`ifdef FIFO_BURST_READER_PARITY_EN
    logic                par0_q, par0_d, par1_q, par1_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
`endif

    assign w_pop = (occ_q != 2'd0) && m_ready;
    // Counting the pop lets a new read issue while the head byte leaves,
    // which sustains one byte per cycle without ever exceeding two slots.
    assign w_space = ({1'b0, occ_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, w_pop});

    always_comb begin
        state_d         = state_q;
        timer_d         = timer_q;
        rd_left_d       = rd_left_q;
        fifo_read       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (fifo_empty) begin
                    timer_d = '0;
                end else if (timer_q != c_tmr_max) begin
                    timer_d = timer_q + 1'b1;
                end
                // Count threshold wins over the timeout.
                if (fifo_count >= c_burst_len) begin
                    state_d   = S_READ;
                    rd_left_d = c_burst_len;
                    timer_d   = '0;
                end else if ((timer_q == c_tmr_max) && !fifo_empty &&
                             (fifo_count != '0)) begin
                    state_d   = S_READ;
                    rd_left_d = fifo_count;
                    timer_d   = '0;
                end
            end
            S_READ: begin
                // Gating with rst keeps the FIFO untouched while reset is held.
                fifo_read = !rst && !fifo_empty && (rd_left_q != '0) && w_space;
                if (fifo_read) begin
                    rd_left_d = rd_left_q - 1'b1;
                    if (rd_left_q == CNT_W'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (w_pop && last0_q) begin
                    state_d = S_IDLE;
                    timer_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        inflight_d      = fifo_read;
        inflight_last_d = fifo_read && (rd_left_q == CNT_W'(1));
    end

    // Buffer: pop shifts entry 1 to the head, then a capture lands in the
    // first free slot, so pop and capture together keep occupancy unchanged.
    always_comb begin
        occ_d   = occ_q;
        data0_d = data0_q;
        data1_d = data1_q;
        last0_d = last0_q;
        last1_d = last1_q;
`ifdef FIFO_BURST_READER_PARITY_EN
        par0_d  = par0_q;
        par1_d  = par1_q;
        acc_d   = acc_q;
`endif
        if (w_pop) begin
            data0_d = data1_q;
            last0_d = last1_q;
`ifdef FIFO_BURST_READER_PARITY_EN
            par0_d  = par1_q;
            if (last0_q) begin
                acc_d = '0;
            end
`endif
            occ_d   = occ_q - 1'b1;
        end
        if (inflight_q) begin
            if (occ_d == 2'd0) begin
                data0_d = fifo_dout;
                last0_d = inflight_last_q;
`ifdef FIFO_BURST_READER_PARITY_EN
                par0_d  = ^fifo_dout;
`endif
            end else begin
                data1_d = fifo_dout;
                last1_d = inflight_last_q;
`ifdef FIFO_BURST_READER_PARITY_EN
                par1_d  = ^fifo_dout;
`endif
            end
`ifdef FIFO_BURST_READER_PARITY_EN
            acc_d = acc_d ^ fifo_dout;
`endif
            occ_d = occ_d + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            timer_q         <= '0;
            rd_left_q       <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            occ_q           <= 2'd0;
            data0_q         <= '0;
            data1_q         <= '0;
            last0_q         <= 1'b0;
            last1_q         <= 1'b0;
`ifdef FIFO_BURST_READER_PARITY_EN
            par0_q          <= 1'b0;
            par1_q          <= 1'b0;
            acc_q           <= '0;
`endif
        end else begin
            state_q         <= state_d;
            timer_q         <= timer_d;
            rd_left_q       <= rd_left_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            occ_q           <= occ_d;
            data0_q         <= data0_d;
            data1_q         <= data1_d;
            last0_q         <= last0_d;
            last1_q         <= last1_d;
`ifdef FIFO_BURST_READER_PARITY_EN
            par0_q          <= par0_d;
            par1_q          <= par1_d;
            acc_q           <= acc_d;
`endif
        end
    end

    assign m_data  = data0_q;
    assign m_valid = (occ_q != 2'd0);
    assign m_last  = last0_q && (occ_q != 2'd0);
    assign busy    = (state_q != S_IDLE);
`ifdef FIFO_BURST_READER_PARITY_EN
    assign m_parity    = par0_q;
    assign parity_byte = acc_q;
`endif

endmodule
`default_nettype wire
